// File: rtl/risc_pkg.sv
// Shared fetch-stage constants and the next-address source encoding.
package risc_pkg;

   localparam int unsigned PC_INCR = 4;

   typedef enum logic [1:0] {
      SRC_SEQ,
      SRC_TGT,
      SRC_RS,
      SRC_RAS
   } nextaddr_src_e;

endpackage

// File: rtl/pc_seq_unit_ret_addr_stack.sv
// Circular return-address stack with occupancy count; a push while full overwrites the oldest entry.
module ret_addr_stack #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full,
   output logic            ovf
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [PTR_W-1:0] w_tp;
   logic [PTR_W-1:0] w_widx;
   logic             w_pop;

   // r_wp is the next free slot; when full it also points at the oldest entry
   assign w_tp   = r_wp - PTR_W'(1);
   assign empty  = (r_cnt == '0);
   assign full   = (r_cnt == CNT_W'(RAS_DEPTH));
   assign w_pop  = pop & ~empty;
   assign w_widx = w_pop ? w_tp : r_wp;
   assign top    = r_mem[w_tp];
   assign ovf    = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= push & ~w_pop & full;
         if (push && !w_pop) begin
            r_wp <= r_wp + PTR_W'(1);
            if (!full) r_cnt <= r_cnt + CNT_W'(1);
         end else if (w_pop && !push) begin
            r_wp  <= w_tp;
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   // Simultaneous push+pop replaces the top in place
   always_ff @(posedge clk) begin
      if (push) r_mem[w_widx] <= din;
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-head program counter: target selection, priority next-address mux, stall-able PC register and RAS.
module pc_seq_unit
   import risc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     BR_W      = 21,
   parameter int unsigned     J_W       = 26,
   parameter bit              PC_REL    = 1'b0,
   parameter int unsigned     RAS_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic [BR_W-1:0] br_addr,
   input  logic [J_W-1:0]  j_addr,
   input  logic [XLEN-1:0] rs,
   input  logic            jb,
   input  logic            jad,
   input  logic            br_val,
   input  logic            jump_val,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] nextaddr,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_seq;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_tgt;
   logic [XLEN-1:0] w_top;
   logic [XLEN-1:0] w_nextaddr;
   logic            w_taken;
   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic            w_full;
   logic            w_ovf;
   nextaddr_src_e   w_src;

   assign w_taken = br_val & jump_val;
   assign w_seq   = r_pc + XLEN'(PC_INCR);
   assign w_imm   = jb ? {{(XLEN-BR_W){br_addr[BR_W-1]}}, br_addr}
                       : {{(XLEN-J_W){j_addr[J_W-1]}}, j_addr};
   assign w_tgt   = jad ? rs : (PC_REL ? (w_seq + w_imm) : w_imm);
   assign w_push  = call & w_taken & ~stall;
   assign w_pop   = ret & ~stall;

   // Return outranks any taken transfer
   always_comb begin
      w_src = SRC_SEQ;
      if (ret && !w_empty)  w_src = SRC_RAS;
      else if (ret)         w_src = SRC_RS;
      else if (w_taken)     w_src = SRC_TGT;
   end

   always_comb begin
      w_nextaddr = w_seq;
      case (w_src)
         SRC_RAS: w_nextaddr = w_top;
         SRC_RS:  w_nextaddr = rs;
         SRC_TGT: w_nextaddr = w_tgt;
         default: w_nextaddr = w_seq;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pc <= RESET_PC;
      else if (!stall) r_pc <= w_nextaddr;
   end

   ret_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_seq),
      .top   (w_top),
      .empty (w_empty),
      .full  (w_full),
      .ovf   (w_ovf)
   );

   assign pc        = r_pc;
   assign nextaddr  = w_nextaddr;
   assign ras_empty = w_empty;
   assign ras_full  = w_full;
   assign ras_ovf   = w_ovf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: absolute-target instance (u0) and PC-relative instance (u1).
module tb_pc_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [20:0] br_addr;
   logic [25:0] j_addr;
   logic [31:0] rs;
   logic        jb, jad, br_val, jump_val, call, ret;

   logic [31:0] pc0, na0, pc1, na1;
   logic        emp0, full0, ovf0, emp1, full1, ovf1;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   pc_seq_unit #(.XLEN(32), .BR_W(21), .J_W(26), .PC_REL(1'b0), .RAS_DEPTH(4),
                 .RESET_PC(32'h100)) u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br_addr(br_addr), .j_addr(j_addr),
      .rs(rs), .jb(jb), .jad(jad), .br_val(br_val), .jump_val(jump_val),
      .call(call), .ret(ret), .pc(pc0), .nextaddr(na0),
      .ras_empty(emp0), .ras_full(full0), .ras_ovf(ovf0));

   pc_seq_unit #(.XLEN(32), .BR_W(21), .J_W(26), .PC_REL(1'b1), .RAS_DEPTH(4),
                 .RESET_PC(32'h100)) u1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br_addr(br_addr), .j_addr(j_addr),
      .rs(rs), .jb(jb), .jad(jad), .br_val(br_val), .jump_val(jump_val),
      .call(call), .ret(ret), .pc(pc1), .nextaddr(na1),
      .ras_empty(emp1), .ras_full(full1), .ras_ovf(ovf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue the PC expected after the next edge, clock, then retire it against u0
   task automatic step(input string tag, input logic [31:0] exp_pc);
      exp_t e;
      sb_q.push_back('{tag, exp_pc});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk(e.tag, pc0, e.val);
   endtask

   task automatic idle_inputs();
      stall = 0; br_addr = '0; j_addr = '0; rs = '0;
      jb = 0; jad = 0; br_val = 0; jump_val = 0; call = 0; ret = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] call_tgt [5];
      logic [31:0] ras_exp  [4];
      call_tgt = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
      ras_exp  = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};

      idle_inputs();
      rst_n = 0;
      #12 rst_n = 1;
      #1;
      chk("reset_pc",     pc0,        32'h100);
      chk("reset_empty",  32'(emp0),  32'd1);
      chk("reset_ovf",    32'(ovf0),  32'd0);
      chk("reset_na_seq", na0,        32'h104);

      step("idle1", 32'h104);
      step("idle2", 32'h108);
      step("idle3", 32'h10C);

      #3 rst_n = 0;
      #1 chk("async_reset_pc", pc0, 32'h100);
      rst_n = 1;

      // absolute jump with sign-extended immediate, then register target
      jump_val = 1; br_val = 1; jb = 0; j_addr = 26'h3FFFFF0;
      #1 chk("abs_jimm", na0, 32'hFFFFFFF0);
      jad = 1; rs = 32'h2000;
      #1 chk("jad_rs", na0, 32'h2000);
      step("jad_pc", 32'h2000);

      rs = 32'h40;
      step("goto_40", 32'h40);
      chk("u1_pc_40", pc1, 32'h40);
      jad = 0; jb = 1; br_addr = 21'h1FFFF8;
      #1 chk("rel_br_neg8", na1, 32'h3C);
      chk("abs_br_neg8", na0, 32'hFFFFFFF8);
      br_val = 0;
      #1 chk("rel_not_taken", na1, 32'h44);
      chk("abs_not_taken", na0, 32'h44);

      br_val = 1; jad = 1; rs = 32'h10;
      step("goto_10", 32'h10);

      // two calls then three returns, last falls back to rs
      jad = 0; jb = 0; call = 1; j_addr = 26'h80;
      #1 chk("call1_na", na0, 32'h80);
      step("call1_pc", 32'h80);
      chk("call1_nonempty", 32'(emp0), 32'd0);
      j_addr = 26'h200;
      step("call2_pc", 32'h200);
      call = 0; jump_val = 0; br_val = 0; ret = 1;
      #1 chk("ret1_na", na0, 32'h84);
      step("ret1_pc", 32'h84);
      chk("ret2_na", na0, 32'h14);
      step("ret2_pc", 32'h14);
      rs = 32'h500;
      #1 chk("ret3_rs_na", na0, 32'h500);
      chk("ret3_empty_before", 32'(emp0), 32'd1);
      step("ret3_pc", 32'h500);
      chk("ret3_empty_after", 32'(emp0), 32'd1);

      // five calls into a 4-deep stack
      ret = 0; call = 1; jump_val = 1; br_val = 1;
      for (int i = 0; i < 5; i++) begin
         j_addr = call_tgt[i][25:0];
         step($sformatf("call_fill%0d", i), call_tgt[i]);
         chk($sformatf("ovf_fill%0d", i), 32'(ovf0), (i == 4) ? 32'd1 : 32'd0);
         if (i >= 3) chk($sformatf("full_fill%0d", i), 32'(full0), 32'd1);
      end
      call = 0; jump_val = 0; br_val = 0; ret = 1; rs = 32'h777;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("ret_drain%0d", i), na0, ras_exp[i]);
         step($sformatf("ret_drain_pc%0d", i), ras_exp[i]);
         if (i == 0) chk("ovf_cleared", 32'(ovf0), 32'd0);
      end
      chk("drained_empty", 32'(emp0), 32'd1);
      #1 chk("ret_drain_rs", na0, 32'h777);
      step("ret_drain_rs_pc", 32'h777);

      // stalled call holds pc and RAS
      ret = 0; call = 1; jump_val = 1; br_val = 1; j_addr = 26'h900; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step($sformatf("stall_pc%0d", i), 32'h777);
         chk($sformatf("stall_empty%0d", i), 32'(emp0), 32'd1);
      end
      stall = 0;
      step("unstall_pc", 32'h900);
      chk("unstall_nonempty", 32'(emp0), 32'd0);

      // call+ret on non-empty stack: take old top, replace it with seq
      ret = 1; jad = 1; rs = 32'hDEAD0;
      #1 chk("callret_ne_na", na0, 32'h77B);
      step("callret_ne_pc", 32'h77B);
      call = 0; jump_val = 0; br_val = 0;
      #1 chk("callret_ne_top", na0, 32'h904);
      step("callret_ne_pop", 32'h904);
      chk("callret_ne_empty", 32'(emp0), 32'd1);

      // call+ret on empty stack: rs target, seq pushed
      call = 1; jump_val = 1; br_val = 1; rs = 32'h600;
      #1 chk("callret_e_na", na0, 32'h600);
      step("callret_e_pc", 32'h600);
      chk("callret_e_nonempty", 32'(emp0), 32'd0);
      call = 0; jump_val = 0; br_val = 0;
      #1 chk("callret_e_top", na0, 32'h908);
      step("callret_e_pop", 32'h908);

      // call without taken does not push
      ret = 0; call = 1; jump_val = 1; br_val = 0;
      step("call_nt_pc", 32'h90C);
      chk("call_nt_empty", 32'(emp0), 32'd1);

      idle_inputs();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
